// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the MIPS-subset core, with a req/ready shared-memory handshake.
// Optional: define MULTICYCLE_ILLEGAL_TRAP_EN to send undecodable instructions to FAULT.
module multicycle_controller #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       func_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_is_data_o,
  output logic             dmem_we_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic [4:0]       alu_op_o,
  output logic             alu_src_imm_o,
  output logic             reg_dst_rd_o,
  output logic             shamt_sel_o,
  output logic             mem_to_reg_o,
  output logic             reg_we_o,
  output logic [2:0]       state_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             fault_o
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned TYPE_W = 5;

  localparam logic [TYPE_W-1:0] T_ADDI  = 5'd0;
  localparam logic [TYPE_W-1:0] T_ADDIU = 5'd1;
  localparam logic [TYPE_W-1:0] T_ADD   = 5'd2;
  localparam logic [TYPE_W-1:0] T_SUB   = 5'd3;
  localparam logic [TYPE_W-1:0] T_AND   = 5'd4;
  localparam logic [TYPE_W-1:0] T_OR    = 5'd5;
  localparam logic [TYPE_W-1:0] T_SLT   = 5'd6;
  localparam logic [TYPE_W-1:0] T_SRL   = 5'd7;
  localparam logic [TYPE_W-1:0] T_SLL   = 5'd8;
  localparam logic [TYPE_W-1:0] T_LUI   = 5'd9;
  localparam logic [TYPE_W-1:0] T_SW    = 5'd10;
  localparam logic [TYPE_W-1:0] T_LW    = 5'd11;
  localparam logic [TYPE_W-1:0] T_BEQ   = 5'd12;
  localparam logic [TYPE_W-1:0] T_J     = 5'd13;
  localparam logic [TYPE_W-1:0] T_ILL   = 5'd14;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [TYPE_W-1:0]  type_q, type_d, dec_type;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_hit;
  logic               is_imm, is_rtype, is_shift;

  // Instruction type from opcode/func; R-type (opcode 0) is resolved by func.
  function automatic logic [TYPE_W-1:0] decode_type(input logic [5:0] op, input logic [5:0] fn);
    logic [TYPE_W-1:0] t;
    t = T_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   t = T_ADD;
          6'h22:   t = T_SUB;
          6'h24:   t = T_AND;
          6'h25:   t = T_OR;
          6'h2A:   t = T_SLT;
          6'h02:   t = T_SRL;
          6'h00:   t = T_SLL;
          default: t = T_ILL;
        endcase
      end
      6'h08:   t = T_ADDI;
      6'h09:   t = T_ADDIU;
      6'h0F:   t = T_LUI;
      6'h2B:   t = T_SW;
      6'h23:   t = T_LW;
      6'h04:   t = T_BEQ;
      6'h02:   t = T_J;
      default: t = T_ILL;
    endcase
    return t;
  endfunction

  assign dec_type = decode_type(opcode_i, func_i);
  assign wait_hit = (wait_q == WAIT_W'(MAX_WAIT));
  assign is_imm   = (type_q == T_ADDI) || (type_q == T_ADDIU) || (type_q == T_LUI) ||
                    (type_q == T_SW)   || (type_q == T_LW);
  assign is_rtype = (type_q >= T_ADD) && (type_q <= T_SLL);
  assign is_shift = (type_q == T_SRL) || (type_q == T_SLL) || (type_q == T_LUI);

  assign state_o      = state_q;
  assign retire_cnt_o = cnt_q;

  // State, type, wait-counter and retire-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      type_q  <= T_ILL;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    wait_d        = '0;
    mem_req_o     = 1'b0;
    mem_is_data_o = 1'b0;
    dmem_we_o     = 1'b0;
    ir_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    pc_src_o      = 2'b00;
    alu_op_o      = '0;
    alu_src_imm_o = 1'b0;
    reg_dst_rd_o  = 1'b0;
    shamt_sel_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_we_o      = 1'b0;
    retire_o      = 1'b0;
    fault_o       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      S_DECODE: begin
        type_d = dec_type;
        if (dec_type == T_J) begin
          pc_we_o  = 1'b1;
          pc_src_o = 2'b10;
          retire_o = 1'b1;
          state_d  = S_FETCH;
        end else if (dec_type == T_ILL) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d  = S_FAULT;
`else
          retire_o = 1'b1;
          state_d  = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op_o      = type_q;
        alu_src_imm_o = is_imm;
        reg_dst_rd_o  = is_rtype;
        shamt_sel_o   = is_shift;
        if (type_q == T_BEQ) begin
          if (zero_i) begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'b01;
          end
          retire_o = 1'b1;
          state_d  = S_FETCH;
        end else if ((type_q == T_LW) || (type_q == T_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_o     = 1'b1;
        mem_is_data_o = 1'b1;
        dmem_we_o     = (type_q == T_SW);
        alu_op_o      = type_q;
        alu_src_imm_o = is_imm;
        reg_dst_rd_o  = is_rtype;
        shamt_sel_o   = is_shift;
        if (mem_ready_i) begin
          if (type_q == T_SW) begin
            retire_o = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      S_WB: begin
        reg_we_o      = 1'b1;
        mem_to_reg_o  = (type_q == T_LW);
        alu_op_o      = type_q;
        alu_src_imm_o = is_imm;
        reg_dst_rd_o  = is_rtype;
        shamt_sel_o   = is_shift;
        retire_o      = 1'b1;
        state_d       = S_FETCH;
      end
      S_FAULT: begin
        fault_o = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // Reset aborts the instruction in flight: drop requests, enables and the retire pulse.
    if (rst_i) begin
      mem_req_o     = 1'b0;
      mem_is_data_o = 1'b0;
      dmem_we_o     = 1'b0;
      ir_we_o       = 1'b0;
      pc_we_o       = 1'b0;
      pc_src_o      = 2'b00;
      alu_op_o      = '0;
      alu_src_imm_o = 1'b0;
      reg_dst_rd_o  = 1'b0;
      shamt_sel_o   = 1'b0;
      mem_to_reg_o  = 1'b0;
      reg_we_o      = 1'b0;
      retire_o      = 1'b0;
      fault_o       = 1'b0;
    end

    cnt_d = retire_o ? CNT_W'(cnt_q + 1'b1) : cnt_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, corner sequences and random
// instruction streams checked cycle by cycle against an instruction-level expected trace.
module tb_multicycle_controller;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode, func;
  logic             zero, mem_ready;
  logic             mem_req, mem_is_data, dmem_we, ir_we, pc_we;
  logic [1:0]       pc_src;
  logic [4:0]       alu_op;
  logic             alu_src_imm, reg_dst_rd, shamt_sel, mem_to_reg, reg_we;
  logic [2:0]       state;
  logic             retire, fault;
  logic [CNT_W-1:0] retire_cnt;

  multicycle_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .func_i(func), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_is_data_o(mem_is_data),
    .dmem_we_o(dmem_we), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
    .alu_op_o(alu_op), .alu_src_imm_o(alu_src_imm), .reg_dst_rd_o(reg_dst_rd),
    .shamt_sel_o(shamt_sel), .mem_to_reg_o(mem_to_reg), .reg_we_o(reg_we),
    .state_o(state), .retire_o(retire), .retire_cnt_o(retire_cnt), .fault_o(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, isd, dwe, irwe, pcwe;
    logic [1:0] pcsrc;
    logic [4:0] aluop;
    logic       imm, rds, sh, m2r, rwe, ret, flt;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] ty;
  } ins_t;

  typedef struct {
    int   k;
    logic z;
    int   fd;
    int   md;
  } vec_t;

  ins_t             tab[16];
  vec_t             vecs[18];
  obs_t             exp_q[$];
  logic             rdy_q[$];
  int               n_pass = 0;
  int               n_total = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state, req: mem_req, isd: mem_is_data, dwe: dmem_we, irwe: ir_we, pcwe: pc_we,
          pcsrc: pc_src, aluop: alu_op, imm: alu_src_imm, rds: reg_dst_rd, sh: shamt_sel,
          m2r: mem_to_reg, rwe: reg_we, ret: retire, flt: fault};
    return o;
  endfunction

  task automatic chk_obs(input string tag, input obs_t want);
    obs_t got;
    got = sample();
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s outputs: got=%h want=%h (state got %0d want %0d)",
                  tag, got, want, got.st, want.st);
  endtask

  task automatic chk_cnt(input string tag);
    n_total++;
    if (retire_cnt === exp_cnt) n_pass++;
    else $display("FAIL %s retire_cnt: got=%0d want=%0d", tag, retire_cnt, exp_cnt);
  endtask

  task automatic push(input obs_t o, input logic r);
    exp_q.push_back(o);
    rdy_q.push_back(r);
  endtask

  // Expected per-cycle trace of one instruction: fd/md are ready delays in FETCH/MEM.
  task automatic build(input int k, input logic z, input int fd, input int md);
    obs_t       o;
    logic [4:0] t;
    logic       imm, rds, sh;
    t   = tab[k].ty;
    imm = (t == 5'd0) || (t == 5'd1) || (t == 5'd9) || (t == 5'd10) || (t == 5'd11);
    rds = (t >= 5'd2) && (t <= 5'd8);
    sh  = (t == 5'd7) || (t == 5'd8) || (t == 5'd9);
    for (int i = 0; i <= fd; i++) begin
      o = '0; o.req = 1'b1;
      if (i == fd) begin o.irwe = 1'b1; o.pcwe = 1'b1; end
      push(o, i == fd);
    end
    o = '0; o.st = 3'd1;
    if (t == 5'd13) begin
      o.pcwe = 1'b1; o.pcsrc = 2'b10; o.ret = 1'b1;
      push(o, 1'b0);
      return;
    end
    if (t == 5'd14) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      push(o, 1'b0);
      o = '0; o.st = 3'd7; o.flt = 1'b1;
      push(o, 1'b0);
`else
      o.ret = 1'b1;
      push(o, 1'b0);
`endif
      return;
    end
    push(o, 1'b0);
    o = '0; o.st = 3'd2; o.aluop = t; o.imm = imm; o.rds = rds; o.sh = sh;
    if (t == 5'd12) begin
      o.pcwe = z; o.pcsrc = z ? 2'b01 : 2'b00; o.ret = 1'b1;
      push(o, 1'b0);
      return;
    end
    push(o, 1'b0);
    if ((t == 5'd10) || (t == 5'd11)) begin
      for (int i = 0; i <= md; i++) begin
        o.st = 3'd3; o.req = 1'b1; o.isd = 1'b1; o.dwe = (t == 5'd10);
        o.ret = (t == 5'd10) && (i == md);
        push(o, i == md);
      end
      if (t == 5'd10) return;
    end
    o.st = 3'd4; o.req = 1'b0; o.isd = 1'b0; o.dwe = 1'b0;
    o.rwe = 1'b1; o.m2r = (t == 5'd11); o.ret = 1'b1;
    push(o, 1'b0);
  endtask

  // Plays the queued trace: drive mem_ready after the edge, compare on the falling edge.
  task automatic run(input string tag);
    int   cyc;
    obs_t e;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      chk_obs($sformatf("%s c%0d", tag, cyc), e);
      chk_cnt($sformatf("%s c%0d", tag, cyc));
      if (e.ret) exp_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic set_ins(input int k, input logic z);
    opcode = tab[k].op;
    func   = (tab[k].op == 6'h00) ? tab[k].fn : 6'($urandom);
    zero   = z;
  endtask

  task automatic do_reset(input logic [2:0] st_in_rst);
    obs_t o;
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    o = '0; o.st = st_in_rst;
    chk_obs("in_reset", o);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    obs_t o;
    tab[0]  = '{6'h08, 6'h00, 5'd0};   tab[1]  = '{6'h09, 6'h00, 5'd1};
    tab[2]  = '{6'h00, 6'h20, 5'd2};   tab[3]  = '{6'h00, 6'h22, 5'd3};
    tab[4]  = '{6'h00, 6'h24, 5'd4};   tab[5]  = '{6'h00, 6'h25, 5'd5};
    tab[6]  = '{6'h00, 6'h2A, 5'd6};   tab[7]  = '{6'h00, 6'h02, 5'd7};
    tab[8]  = '{6'h00, 6'h00, 5'd8};   tab[9]  = '{6'h0F, 6'h00, 5'd9};
    tab[10] = '{6'h2B, 6'h00, 5'd10};  tab[11] = '{6'h23, 6'h00, 5'd11};
    tab[12] = '{6'h04, 6'h00, 5'd12};  tab[13] = '{6'h02, 6'h00, 5'd13};
    tab[14] = '{6'h3F, 6'h00, 5'd14};  tab[15] = '{6'h00, 6'h3F, 5'd14};

    vecs[0]  = '{2,  1'b0, 0, 0};  vecs[1]  = '{11, 1'b0, 0, 3};
    vecs[2]  = '{12, 1'b1, 0, 0};  vecs[3]  = '{12, 1'b0, 0, 0};
    vecs[4]  = '{13, 1'b0, 0, 0};  vecs[5]  = '{10, 1'b0, 0, 0};
    vecs[6]  = '{0,  1'b1, 2, 0};  vecs[7]  = '{1,  1'b0, 1, 0};
    vecs[8]  = '{3,  1'b0, 0, 0};  vecs[9]  = '{4,  1'b0, 0, 0};
    vecs[10] = '{5,  1'b0, 0, 0};  vecs[11] = '{6,  1'b0, 0, 0};
    vecs[12] = '{7,  1'b0, 0, 0};  vecs[13] = '{8,  1'b0, 0, 0};
    vecs[14] = '{9,  1'b0, 0, 0};  vecs[15] = '{2,  1'b0, MAX_WAIT, 0};
    vecs[16] = '{10, 1'b0, 1, MAX_WAIT};  vecs[17] = '{11, 1'b1, MAX_WAIT, MAX_WAIT};

    rst = 1'b1; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(3'd0);

    for (int v = 0; v < 18; v++) begin
      set_ins(vecs[v].k, vecs[v].z);
      build(vecs[v].k, vecs[v].z, vecs[v].fd, vecs[v].md);
      run($sformatf("vec%0d", v));
    end

    // Abort a store while it is waiting in MEM; ready in the reset cycle must not retire it.
    set_ins(10, 1'b0);
    build(10, 1'b0, 0, 3);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_back());
    for (int i = 0; i < 3; i++) void'(rdy_q.pop_back());
    run("sw_abort");
    do_reset(3'd3);
    set_ins(13, 1'b0);
    build(13, 1'b0, 0, 0);
    run("after_abort");

    // Unknown opcode and unknown R-type func.
    for (int k = 14; k < 16; k++) begin
      set_ins(k, 1'b0);
      build(k, 1'b0, 0, 0);
      run($sformatf("illegal%0d", k));
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      do_reset(3'd7);
`endif
    end

    // Fetch never answered: FAULT after MAX_WAIT+1 waiting cycles, sticky until reset.
    for (int i = 0; i <= MAX_WAIT; i++) begin
      o = '0; o.req = 1'b1;
      push(o, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      o = '0; o.st = 3'd7; o.flt = 1'b1;
      push(o, 1'b1);
    end
    run("fetch_timeout");
    do_reset(3'd7);
    set_ins(2, 1'b0);
    build(2, 1'b0, 0, 0);
    run("after_fault");

    // Random legal instruction stream with random ready delays up to the wait limit.
    for (int n = 0; n < 200; n++) begin
      int   k, fd, md;
      logic z;
      k  = int'($urandom_range(0, 13));
      z  = 1'($urandom_range(0, 1));
      fd = int'($urandom_range(0, MAX_WAIT));
      md = int'($urandom_range(0, MAX_WAIT));
      set_ins(k, z);
      build(k, z, fd, md);
      run($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
